// File: rtl/map_descriptor_receive_pkg.sv
// map_descriptor_receive_pkg: descriptor field widths and input FSM encoding
// shared with the host-receive lookup stage.
package map_descriptor_receive_pkg;
   localparam int TSNTAG_W = 48;
   localparam int BUFID_W  = 9;
   localparam int DESC_W   = TSNTAG_W + BUFID_W;
   typedef enum logic [1:0] {
      IDLE_S = 2'd0,
      ACK_S  = 2'd1
   } state_t;
endpackage

// File: rtl/map_descriptor_receive_if.sv
// map_descriptor_receive_if: descriptor write/ack side, FWFT pop side and statistics.
interface map_descriptor_receive_if
   import map_descriptor_receive_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int CNT_W      = 16
);
   logic [TSNTAG_W-1:0] iv_tsntag;
   logic [BUFID_W-1:0]  iv_bufid;
   logic                i_descriptor_wr;
   logic                o_descriptor_ack;
   logic [TSNTAG_W-1:0] ov_tsntag;
   logic [BUFID_W-1:0]  ov_bufid;
   logic                o_descriptor_valid;
   logic                i_descriptor_ready;
   logic [DEPTH_LOG2:0] ov_fifo_usedw;
   logic                o_fifo_full;
   logic [CNT_W-1:0]    ov_accept_cnt;
   logic [CNT_W-1:0]    ov_stall_cnt;
   modport slave (
      input  iv_tsntag, iv_bufid, i_descriptor_wr, i_descriptor_ready,
      output o_descriptor_ack, ov_tsntag, ov_bufid, o_descriptor_valid,
             ov_fifo_usedw, o_fifo_full, ov_accept_cnt, ov_stall_cnt
   );
   modport master (
      output iv_tsntag, iv_bufid, i_descriptor_wr, i_descriptor_ready,
      input  o_descriptor_ack, ov_tsntag, ov_bufid, o_descriptor_valid,
             ov_fifo_usedw, o_fifo_full, ov_accept_cnt, ov_stall_cnt
   );
endinterface

// File: rtl/map_descriptor_receive_fifo.sv
// desc_reg_fifo: register FIFO with first-word fall-through read and occupancy count.
module desc_reg_fifo #(
   parameter int W          = 57,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_push,
   input  logic [W-1:0]        iv_wdata,
   input  logic                i_pop,
   output logic [W-1:0]        ov_rdata,
   output logic [DEPTH_LOG2:0] ov_usedw,
   output logic                o_full,
   output logic                o_empty
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   logic [W-1:0]          mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic                  push_en, pop_en;
   assign o_full   = ov_usedw == (DEPTH_LOG2+1)'(DEPTH);
   assign o_empty  = ov_usedw == '0;
   assign push_en  = i_push && !o_full;
   assign pop_en   = i_pop && !o_empty;
   assign ov_rdata = mem[rptr];
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         ov_usedw <= '0;
      end else begin
         wptr     <= wptr + DEPTH_LOG2'(push_en);
         rptr     <= rptr + DEPTH_LOG2'(pop_en);
         ov_usedw <= ov_usedw + (DEPTH_LOG2+1)'(push_en) - (DEPTH_LOG2+1)'(pop_en);
      end
   end
   always_ff @(posedge i_clk) begin
      if (push_en) mem[wptr] <= iv_wdata;
   end
endmodule

// File: rtl/map_descriptor_receive.sv
// map_descriptor_receive: acks lookup-stage descriptors, buffers them in a register
// FIFO and forwards them FWFT to the queue manager, counting accepts and stalls.
module map_descriptor_receive
   import map_descriptor_receive_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int CNT_W      = 16
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   map_descriptor_receive_if.slave bus
);
   state_t              state, state_nx;
   logic                ack, ack_nx;
   logic                push, stall, full, empty;
   logic [CNT_W-1:0]    accept_cnt, stall_cnt;
   logic [DESC_W-1:0]   head;
   logic [DEPTH_LOG2:0] usedw;
   // full comes from the registered occupancy, so a same-cycle pop cannot unblock a push
   assign push  = state == IDLE_S && bus.i_descriptor_wr && !full;
   assign stall = state == IDLE_S && bus.i_descriptor_wr && full;
   always_comb begin
      state_nx = push ? ACK_S : IDLE_S;
      ack_nx   = push;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE_S;
         ack        <= 1'b0;
         accept_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_nx;
         ack        <= ack_nx;
         accept_cnt <= accept_cnt + CNT_W'(push);
         stall_cnt  <= stall_cnt + CNT_W'(stall);
      end
   end
   desc_reg_fifo #(.W(DESC_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_push   (push),
      .iv_wdata ({bus.iv_tsntag, bus.iv_bufid}),
      .i_pop    (bus.i_descriptor_ready),
      .ov_rdata (head),
      .ov_usedw (usedw),
      .o_full   (full),
      .o_empty  (empty)
   );
   // head is forced to zero when empty so outputs read 0 out of reset
   assign {bus.ov_tsntag, bus.ov_bufid} = empty ? '0 : head;
   assign bus.o_descriptor_ack   = ack;
   assign bus.o_descriptor_valid = !empty;
   assign bus.ov_fifo_usedw      = usedw;
   assign bus.o_fifo_full        = full;
   assign bus.ov_accept_cnt      = accept_cnt;
   assign bus.ov_stall_cnt       = stall_cnt;
endmodule

// File: tb/tb_map_descriptor_receive.sv
// tb_map_descriptor_receive: directed scenario tasks with hand-computed expectations.
module tb_map_descriptor_receive;
   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   map_descriptor_receive_if #(.DEPTH_LOG2(3), .CNT_W(16)) bus ();
   map_descriptor_receive #(.DEPTH_LOG2(3), .CNT_W(16)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [47:0] tag_of(input int id);
      return 48'h0000_A000_0000 | 48'(id);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_descriptor_wr = 1'b0;
      bus.i_descriptor_ready = 1'b0;
      bus.iv_tsntag = '0;
      bus.iv_bufid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // raise wr with data and hold until ack is seen; returns just after the ack edge
   task automatic send(input logic [47:0] tag, input logic [8:0] id);
      bit ok = 0;
      bus.iv_tsntag = tag;
      bus.iv_bufid = id;
      bus.i_descriptor_wr = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (bus.o_descriptor_ack) begin ok = 1; break; end
      end
      bus.i_descriptor_wr = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL send_timeout bufid=%0d: ack=0 required 1", id); end
   endtask

   task automatic drain(input int first, input int last, input string name);
      for (int i = first; i <= last; i++) begin
         checks++;
         if (bus.o_descriptor_valid !== 1'b1 || bus.ov_bufid !== 9'(i) || bus.ov_tsntag !== tag_of(i)) begin
            errors++;
            $display("FAIL %s_order: valid=%0b bufid=%0d tag=%h required valid=1 bufid=%0d tag=%h",
                     name, bus.o_descriptor_valid, bus.ov_bufid, bus.ov_tsntag, i, tag_of(i));
         end
         bus.i_descriptor_ready = 1'b1;
         @(posedge clk); #1;
         bus.i_descriptor_ready = 1'b0;
      end
      checks++;
      if (bus.o_descriptor_valid !== 1'b0) begin errors++; $display("FAIL %s_empty: valid=%0b required 0", name, bus.o_descriptor_valid); end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      bus.i_descriptor_wr = 1'b0;
      bus.i_descriptor_ready = 1'b0;
      bus.iv_tsntag = '0;
      bus.iv_bufid = '0;
      @(posedge clk); #1;
      checks++;
      if ({bus.o_descriptor_ack, bus.o_descriptor_valid, bus.o_fifo_full, bus.ov_fifo_usedw,
           bus.ov_tsntag, bus.ov_bufid, bus.ov_accept_cnt, bus.ov_stall_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%0b valid=%0b full=%0b usedw=%0d tag=%h bufid=%0d acc=%0d stall=%0d required all 0",
                  bus.o_descriptor_ack, bus.o_descriptor_valid, bus.o_fifo_full, bus.ov_fifo_usedw,
                  bus.ov_tsntag, bus.ov_bufid, bus.ov_accept_cnt, bus.ov_stall_cnt);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      bus.iv_tsntag = 48'h0001_0000_0005;
      bus.iv_bufid = 9'd17;
      bus.i_descriptor_wr = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.o_descriptor_ack !== 1'b1 || bus.ov_fifo_usedw !== 4'd1) begin
         errors++; $display("FAIL single_ack: ack=%0b usedw=%0d required ack=1 usedw=1", bus.o_descriptor_ack, bus.ov_fifo_usedw);
      end
      bus.i_descriptor_wr = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.o_descriptor_ack !== 1'b0 || bus.o_descriptor_valid !== 1'b1 ||
          bus.ov_tsntag !== 48'h0001_0000_0005 || bus.ov_bufid !== 9'd17) begin
         errors++;
         $display("FAIL single_head: ack=%0b valid=%0b tag=%h bufid=%0d required ack=0 valid=1 tag=000100000005 bufid=17",
                  bus.o_descriptor_ack, bus.o_descriptor_valid, bus.ov_tsntag, bus.ov_bufid);
      end
      bus.i_descriptor_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_descriptor_ready = 1'b0;
      checks++;
      if (bus.o_descriptor_valid !== 1'b0 || bus.ov_accept_cnt !== 16'd1) begin
         errors++; $display("FAIL single_pop: valid=%0b acc=%0d required valid=0 acc=1", bus.o_descriptor_valid, bus.ov_accept_cnt);
      end
   endtask

   task automatic test_stale_level();
      do_reset();
      bus.iv_tsntag = tag_of(3);
      bus.iv_bufid = 9'd3;
      bus.i_descriptor_wr = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.o_descriptor_ack !== 1'b1) begin errors++; $display("FAIL stale_first_ack: ack=%0b required 1", bus.o_descriptor_ack); end
      @(posedge clk); #1;
      bus.i_descriptor_wr = 1'b0;
      checks++;
      if (bus.o_descriptor_ack !== 1'b0 || bus.ov_fifo_usedw !== 4'd1) begin
         errors++; $display("FAIL stale_ignored: ack=%0b usedw=%0d required ack=0 usedw=1", bus.o_descriptor_ack, bus.ov_fifo_usedw);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.o_descriptor_ack !== 1'b0 || bus.ov_fifo_usedw !== 4'd1 || bus.ov_accept_cnt !== 16'd1) begin
         errors++; $display("FAIL stale_single_push: ack=%0b usedw=%0d acc=%0d required 0 1 1",
                            bus.o_descriptor_ack, bus.ov_fifo_usedw, bus.ov_accept_cnt);
      end
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int i = 0; i < 8; i++) send(tag_of(i), 9'(i));
      checks++;
      if (bus.o_fifo_full !== 1'b1 || bus.ov_fifo_usedw !== 4'd8) begin
         errors++; $display("FAIL full_flag: full=%0b usedw=%0d required full=1 usedw=8", bus.o_fifo_full, bus.ov_fifo_usedw);
      end
      @(posedge clk); #1;
      bus.iv_tsntag = tag_of(8);
      bus.iv_bufid = 9'd8;
      bus.i_descriptor_wr = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.o_descriptor_ack !== 1'b0 || bus.ov_stall_cnt !== 16'd5 || bus.ov_fifo_usedw !== 4'd8) begin
         errors++; $display("FAIL full_stall: ack=%0b stall=%0d usedw=%0d required ack=0 stall=5 usedw=8",
                            bus.o_descriptor_ack, bus.ov_stall_cnt, bus.ov_fifo_usedw);
      end
      checks++;
      if (bus.ov_bufid !== 9'd0) begin errors++; $display("FAIL full_head: bufid=%0d required 0", bus.ov_bufid); end
      bus.i_descriptor_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_descriptor_ready = 1'b0;
      checks++;
      if (bus.o_descriptor_ack !== 1'b0 || bus.ov_stall_cnt !== 16'd6 || bus.ov_fifo_usedw !== 4'd7) begin
         errors++; $display("FAIL full_pop_same_cycle: ack=%0b stall=%0d usedw=%0d required ack=0 stall=6 usedw=7",
                            bus.o_descriptor_ack, bus.ov_stall_cnt, bus.ov_fifo_usedw);
      end
      @(posedge clk); #1;
      bus.i_descriptor_wr = 1'b0;
      checks++;
      if (bus.o_descriptor_ack !== 1'b1 || bus.ov_fifo_usedw !== 4'd8 || bus.ov_accept_cnt !== 16'd9 || bus.ov_stall_cnt !== 16'd6) begin
         errors++; $display("FAIL full_late_accept: ack=%0b usedw=%0d acc=%0d stall=%0d required 1 8 9 6",
                            bus.o_descriptor_ack, bus.ov_fifo_usedw, bus.ov_accept_cnt, bus.ov_stall_cnt);
      end
      drain(1, 8, "full_drain");
   endtask

   task automatic test_push_pop();
      do_reset();
      for (int i = 0; i < 4; i++) send(tag_of(i), 9'(i));
      @(posedge clk); #1;
      bus.iv_tsntag = tag_of(4);
      bus.iv_bufid = 9'd4;
      bus.i_descriptor_wr = 1'b1;
      bus.i_descriptor_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_descriptor_wr = 1'b0;
      bus.i_descriptor_ready = 1'b0;
      checks++;
      if (bus.o_descriptor_ack !== 1'b1 || bus.ov_fifo_usedw !== 4'd4) begin
         errors++; $display("FAIL pushpop_usedw: ack=%0b usedw=%0d required ack=1 usedw=4", bus.o_descriptor_ack, bus.ov_fifo_usedw);
      end
      drain(1, 4, "pushpop");
   endtask

   task automatic test_wrap();
      do_reset();
      bus.i_descriptor_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         send(tag_of(i), 9'(i));
         checks++;
         if (bus.o_descriptor_valid !== 1'b1 || bus.ov_bufid !== 9'(i) || bus.ov_fifo_usedw > 4'd1) begin
            errors++; $display("FAIL wrap_stream: valid=%0b bufid=%0d usedw=%0d required valid=1 bufid=%0d usedw<=1",
                               bus.o_descriptor_valid, bus.ov_bufid, bus.ov_fifo_usedw, i);
         end
      end
      @(posedge clk); #1;
      bus.i_descriptor_ready = 1'b0;
      checks++;
      if (bus.ov_fifo_usedw !== 4'd0 || bus.ov_accept_cnt !== 16'd20) begin
         errors++; $display("FAIL wrap_final: usedw=%0d acc=%0d required usedw=0 acc=20", bus.ov_fifo_usedw, bus.ov_accept_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) send(tag_of(i), 9'(i));
      checks++;
      if (bus.o_descriptor_ack !== 1'b1 || bus.ov_fifo_usedw !== 4'd5) begin
         errors++; $display("FAIL mid_setup: ack=%0b usedw=%0d required ack=1 usedw=5", bus.o_descriptor_ack, bus.ov_fifo_usedw);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.o_descriptor_ack, bus.o_descriptor_valid, bus.o_fifo_full, bus.ov_fifo_usedw,
           bus.ov_tsntag, bus.ov_bufid, bus.ov_accept_cnt, bus.ov_stall_cnt} !== '0) begin
         errors++; $display("FAIL mid_reset_async: ack=%0b valid=%0b usedw=%0d bufid=%0d acc=%0d required all 0",
                            bus.o_descriptor_ack, bus.o_descriptor_valid, bus.ov_fifo_usedw, bus.ov_bufid, bus.ov_accept_cnt);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(tag_of(300), 9'd300);
      checks++;
      if (bus.ov_accept_cnt !== 16'd1 || bus.ov_fifo_usedw !== 4'd1 || bus.ov_bufid !== 9'd300 || bus.ov_tsntag !== tag_of(300)) begin
         errors++; $display("FAIL mid_after_release: acc=%0d usedw=%0d bufid=%0d required acc=1 usedw=1 bufid=300",
                            bus.ov_accept_cnt, bus.ov_fifo_usedw, bus.ov_bufid);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stale_level();
      test_fill_full();
      test_push_pop();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/map_descriptor_receive.md
Name: map_descriptor_receive

Overview:
- Receiving end of the descriptor handshake driven by the host-receive map/lookup stage.
- That stage presents {tsntag[47:0], bufid[8:0]} on a write-level-and-ack handshake. This block acknowledges each descriptor and buffers it in a small register FIFO.
- It forwards descriptors downstream on a first-word-fall-through valid/ready interface to the host-receive queue manager, and keeps per-block statistics.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (legal 1..5).
- CNT_W, 16, width of the accepted/stall statistic counters.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- iv_tsntag  input  48  descriptor TSN tag from the lookup stage.
- iv_bufid  input  9  packet buffer id from the lookup stage.
- i_descriptor_wr  input  1  level request; held with stable data until acked.
- o_descriptor_ack  output  1  one-cycle acknowledge pulse.
- ov_tsntag  output  48  head-of-FIFO tag.
- ov_bufid  output  9  head-of-FIFO buffer id.
- o_descriptor_valid  output  1  FIFO non-empty.
- i_descriptor_ready  input  1  downstream pop; a pop occurs when valid && ready.
- ov_fifo_usedw  output  DEPTH_LOG2+1  current occupancy.
- o_fifo_full  output  1  occupancy == depth.
- ov_accept_cnt  output  CNT_W  descriptors accepted; wraps modulo 2**CNT_W.
- ov_stall_cnt  output  CNT_W  cycles with wr high in IDLE_S while full; wraps.

Behaviour:
- Reset: every output is 0. The FIFO is empty, the FSM is in IDLE_S, and the read/write pointers are 0. Reset mid-operation discards all buffered descriptors. The sender restarts from its own reset.
- Input FSM:
  - IDLE_S: if i_descriptor_wr=1 and not full, write {iv_tsntag, iv_bufid} to the FIFO, drive o_descriptor_ack<=1, go to ACK_S. If wr=1 and full, ack stays 0, increment ov_stall_cnt, stay. If wr=0, stay.
  - ACK_S: o_descriptor_ack<=0, go to IDLE_S unconditionally. wr sampled in this cycle is the sender's stale level and is ignored, so no double-accept occurs.
  - Any undefined state: clear ack, go to IDLE_S.
- Handshake timing: ack rises on the clock edge after wr is first sampled high with space available. Ack lasts exactly one cycle. Back-to-back descriptors are accepted no faster than one per 2 cycles.
- FIFO:
  - Register array, pointers DEPTH_LOG2 bits, wrapping naturally. Occupancy is a separate counter, DEPTH_LOG2+1 bits.
  - ov_tsntag/ov_bufid show the entry at the read pointer combinationally (first-word fall-through). They are valid only while o_descriptor_valid=1.
  - The push occurs in the IDLE_S accept cycle. The entry is visible on the output the cycle after the ack rises.
  - Simultaneous push and pop: occupancy unchanged, both pointers advance.
  - Pop while empty: ignored.
  - Full: push is blocked by the FSM. A pop in the same cycle the FSM samples full does not allow acceptance until the next cycle (full is a registered decision).
  - o_fifo_full = (usedw == 2**DEPTH_LOG2).
- Statistics: ov_accept_cnt increments on each push. Both counters wrap silently and have no clear input other than reset.
- Data ordering: strict FIFO order, no reordering or filtering. A tsntag of 0 is a legal value.

Decomposition:
- Shared package/header: descriptor field widths (TSNTAG_W=48, BUFID_W=9, DESC_W=57) and the FSM state encodings IDLE_S=2'd0, ACK_S=2'd1. The lookup stage uses the same width constants.
- One natural sub-module: desc_reg_fifo (parameterised register FIFO, FWFT, with usedw/full/empty). The FSM and counters stay in the top.

Test Plan:
- Single descriptor: wr=1 with tsntag=48'h0001_0000_0005, bufid=9'd17, sender drops wr on ack → ack high for exactly 1 cycle, one cycle after wr is sampled; next cycle valid=1, ov_tsntag=48'h0001_0000_0005, ov_bufid=17; ready=1 → valid=0, accept_cnt=1.
- Stale-level check: sender holds wr high one extra cycle after the ack edge (models registered drop) → exactly one push, usedw=1, no second ack.
- Fill to full with DEPTH_LOG2=3 and ready=0: send 9 descriptors bufid 0..8 → 8 acks, full=1, usedw=8; the 9th wr is held unacked and stall_cnt increments each IDLE_S cycle. Pulse ready once → 9th is acked 2–3 cycles later. Drain order is bufid 0..8.
- Simultaneous push/pop at usedw=4 → usedw stays 4, output order preserved.
- Pointer wrap: stream 20 descriptors with ready=1 → outputs bufid 0..19 in order, usedw never exceeds 1, accept_cnt=20.
- Reset mid-stream with usedw=5 and ack high → all outputs 0 immediately, valid=0, accept_cnt=0; after release, a new descriptor is accepted normally.
